// File: rtl/parameter_pkg.sv
// rtl/parameter_pkg.sv - sizing constants shared by the rename free list
package parameter_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int PHY_WIDTH = $clog2(PHY_REGS);
  localparam int FL_DEPTH  = PHY_REGS - ARCH_REGS;
  // Pointer carries one extra wrap bit above the array index.
  localparam int FL_PTR_W  = $clog2(FL_DEPTH) + 1;
  localparam int FL_IDX_W  = FL_PTR_W - 1;

endpackage

// File: rtl/typedef_pkg.sv
// rtl/typedef_pkg.sv - tag and pointer types for the rename free list
package typedef_pkg;

  import parameter_pkg::*;

  typedef logic [PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;
  typedef logic [FL_IDX_W-1:0]  fl_idx_t;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical tags with flush recovery
module free_list
  import parameter_pkg::*;
  import typedef_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_ready,
  output logic [1:0]           alloc_valid,
  output logic [PHY_WIDTH-1:0] alloc_phy_0,
  output logic [PHY_WIDTH-1:0] alloc_phy_1,
  input  logic                 retire_valid,
  input  logic                 retire_has_rd,
  input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
  output logic [PHY_WIDTH:0]   free_count
);

  phy_tag_t fl [FL_DEPTH];

  // head: next tag to hand out speculatively; commit_head: head as seen by
  // retired instructions only; tail: next slot to receive a freed tag.
  fl_ptr_t head;
  fl_ptr_t commit_head;
  fl_ptr_t tail;

  fl_ptr_t head_nxt;
  fl_ptr_t commit_head_nxt;
  fl_ptr_t tail_nxt;
  fl_ptr_t avail;
  fl_ptr_t spec_cnt;
  fl_ptr_t live_cnt;
  fl_idx_t head_idx_p1;
  logic    fire;
  logic    free_en;
  logic [1:0] alloc_cnt;

  // Grants, counts and next-pointer values, all combinational from state.
  always_comb begin
    avail        = tail - head;
    spec_cnt     = head - commit_head;
    live_cnt     = tail - commit_head;
    free_count   = (PHY_WIDTH+1)'(avail);
    // Two free entries are required even for a single request so rename
    // never has to reason about which slot fits.
    alloc_ready  = (avail >= FL_PTR_W'(2));
    fire         = alloc_ready & ~stall & ~flush;
    alloc_valid  = alloc_req & {2{fire}};
    head_idx_p1  = head[FL_IDX_W-1:0] + FL_IDX_W'(1);
    alloc_phy_0  = fl[head[FL_IDX_W-1:0]];
    // Slot 1 alone takes the head entry rather than skipping it.
    alloc_phy_1  = alloc_req[0] ? fl[head_idx_p1] : fl[head[FL_IDX_W-1:0]];
    alloc_cnt    = fire ? (2'(alloc_req[0]) + 2'(alloc_req[1])) : 2'd0;
    free_en      = retire_valid & retire_has_rd;
    commit_head_nxt = commit_head + FL_PTR_W'(free_en);
    tail_nxt        = tail + FL_PTR_W'(free_en);
    // Flush rewinds to the committed head, including a same-cycle retire.
    head_nxt     = flush ? commit_head_nxt : head + FL_PTR_W'(alloc_cnt);
  end

  // Pointer update and tag write-back; reset refills the list with the
  // tags above the architectural range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= {1'b1, {FL_IDX_W{1'b0}}};
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
    end else begin
      head        <= head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      if (free_en) begin
        fl[tail[FL_IDX_W-1:0]] <= rd_phy_old_commit;
      end
    end
  end

  a_free_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    free_en |-> (avail != FL_PTR_W'(FL_DEPTH)));

  a_free_not_p0: assert property (@(posedge clk) disable iff (!rst_n)
    free_en |-> (rd_phy_old_commit != '0));

  a_head_order: assert property (@(posedge clk) disable iff (!rst_n)
    spec_cnt <= live_cnt);

  a_live_bound: assert property (@(posedge clk) disable iff (!rst_n)
    live_cnt <= FL_PTR_W'(FL_DEPTH));

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for the rename free list
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       flush;
  logic [1:0] alloc_req;
  logic       alloc_ready;
  logic [1:0] alloc_valid;
  logic [5:0] alloc_phy_0;
  logic [5:0] alloc_phy_1;
  logic       retire_valid;
  logic       retire_has_rd;
  logic [5:0] rd_phy_old_commit;
  logic [6:0] free_count;

  free_list dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .flush             (flush),
    .alloc_req         (alloc_req),
    .alloc_ready       (alloc_ready),
    .alloc_valid       (alloc_valid),
    .alloc_phy_0       (alloc_phy_0),
    .alloc_phy_1       (alloc_phy_1),
    .retire_valid      (retire_valid),
    .retire_has_rd     (retire_has_rd),
    .rd_phy_old_commit (rd_phy_old_commit),
    .free_count        (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         fc;
    int         rdy;
    logic [1:0] vld;
    int         hfc;
  } st_t;

  typedef struct {
    int         cyc;
    logic [1:0] vld;
    int         t0;
    int         t1;
    int         h0;
    int         h1;
  } gr_t;

  st_t st_q[$];
  gr_t gr_q[$];

  // Reference model: ordered free tags, speculatively granted tags in
  // program order, and the committed architectural tags (excluding p0).
  int free_q[$];
  int spec_q[$];
  int arch_q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  st_t ms;
  gr_t mg;

  always @(negedge clk) begin
    if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
      ms = st_q.pop_front();
      chk("free_count", int'(free_count), ms.fc);
      chk("alloc_ready", int'(alloc_ready), ms.rdy);
      chk("alloc_valid", int'(alloc_valid), int'(ms.vld));
      if (ms.hfc >= 0) chk("free_count_hand", int'(free_count), ms.hfc);
    end
    while (gr_q.size() != 0 && gr_q[0].cyc < cyc) begin
      mg = gr_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL grant_missing cycle %0d: got no grant expected valid %0d", mg.cyc, mg.vld);
    end
    if (alloc_valid != 2'b00) begin
      if (gr_q.size() != 0 && gr_q[0].cyc == cyc) begin
        mg = gr_q.pop_front();
        if (mg.vld[0]) chk("alloc_phy_0", int'(alloc_phy_0), mg.t0);
        if (mg.vld[1]) chk("alloc_phy_1", int'(alloc_phy_1), mg.t1);
        if (mg.h0 >= 0) chk("alloc_phy_0_hand", int'(alloc_phy_0), mg.h0);
        if (mg.h1 >= 0) chk("alloc_phy_1_hand", int'(alloc_phy_1), mg.h1);
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_unexpected cycle %0d: got valid %0d expected none", cyc, alloc_valid);
      end
    end
  end

  // One cycle of stimulus: record expectations from the model, then
  // advance the model as the DUT will at the coming posedge.
  task automatic step(input logic [1:0] req, input logic stl, input logic fls,
                      input logic rv, input logic rhd, input int old = 0,
                      input int hfc = -1, input int h0 = -1, input int h1 = -1);
    st_t s;
    gr_t g;
    bit  fire;
    alloc_req         = req;
    stall             = stl;
    flush             = fls;
    retire_valid      = rv;
    retire_has_rd     = rhd;
    rd_phy_old_commit = 6'(old);
    s.cyc = cyc;
    s.fc  = free_q.size();
    s.rdy = (free_q.size() >= 2) ? 1 : 0;
    fire  = (s.rdy == 1) && !stl && !fls;
    s.vld = fire ? req : 2'b00;
    s.hfc = hfc;
    st_q.push_back(s);
    if (fire && req != 2'b00) begin
      g.cyc = cyc;
      g.vld = req;
      g.t0  = free_q[0];
      g.t1  = req[0] ? free_q[1] : free_q[0];
      g.h0  = h0;
      g.h1  = h1;
      gr_q.push_back(g);
      repeat (int'(req[0]) + int'(req[1])) spec_q.push_back(free_q.pop_front());
    end
    if (rv && rhd) begin
      void'(spec_q.pop_front());
      free_q.push_back(old);
    end
    if (fls) begin
      for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
      spec_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    free_q.delete();
    spec_q.delete();
    arch_q.delete();
    for (int t = 32; t < 64; t++) free_q.push_back(t);
    for (int t = 1; t < 32; t++) arch_q.push_back(t);
    step(2'b00, 0, 0, 0, 0, 0, 32);
    step(2'b00, 0, 0, 0, 0, 0, 32);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] req;
    logic       stl, fls, rv, rhd;
    int         old;
    logic [1:0] pat [4];
    pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11;
    rst_n = 1'b0; stall = 0; flush = 0; alloc_req = 0;
    retire_valid = 0; retire_has_rd = 0; rd_phy_old_commit = 0;
    #1;

    // Reset then dual allocate.
    do_reset();
    step(2'b11, 0, 0, 0, 0, 0, 32, 32, 33);
    step(2'b11, 0, 0, 0, 0, 0, 30, 34, 35);
    step(2'b11, 0, 0, 0, 0, 0, 28, 36, 37);
    step(2'b00, 0, 0, 0, 0, 0, 26);

    // Slot 1 alone takes the head entry; head moves by one.
    do_reset();
    step(2'b11, 0, 0, 0, 0, 0, 32, 32, 33);
    step(2'b11, 0, 0, 0, 0, 0, 30, 34, 35);
    step(2'b10, 0, 0, 0, 0, 0, 28, -1, 36);
    step(2'b11, 0, 0, 0, 0, 0, 27, 37, 38);
    step(2'b00, 0, 0, 0, 0, 0, 25);

    // Drain to the limit, then refill through the wrapped array slots.
    do_reset();
    for (int k = 0; k < 15; k++) step(2'b11, 0, 0, 0, 0, 0, 32 - 2 * k);
    step(2'b11, 0, 0, 0, 0, 0, 2, 62, 63);
    step(2'b11, 0, 0, 1, 1, 40, 0);
    step(2'b11, 0, 0, 1, 1, 41, 1);
    step(2'b00, 0, 0, 0, 0, 0, 2);
    step(2'b11, 0, 0, 0, 0, 0, 2, 40, 41);

    // Flush recovery with a same-cycle retire.
    do_reset();
    step(2'b11, 0, 0, 0, 0, 0, 32);
    step(2'b11, 0, 0, 0, 0, 0, 30);
    step(2'b11, 0, 0, 0, 0, 0, 28);
    step(2'b00, 0, 0, 1, 1, 5, 26);
    step(2'b00, 0, 0, 1, 1, 7, 27);
    step(2'b11, 0, 1, 1, 1, 9, 28);
    step(2'b11, 0, 0, 0, 0, 0, 32, 35, 36);

    // Stall with retire, then allocate one alongside a retire.
    step(2'b11, 1, 0, 1, 1, 11, 30);
    step(2'b01, 0, 0, 1, 1, 12, 31, 37);
    step(2'b00, 0, 0, 1, 0, 0, 31);
    step(2'b00, 0, 0, 0, 0, 0, 31);

    // Wrap-around traffic with stalls and flushes mixed in.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      req = pat[i % 4];
      stl = (i % 7 == 6);
      fls = (i % 17 == 16);
      rv  = (spec_q.size() > 0) && (i % 3 != 1);
      rhd = rv && (i % 5 != 4);
      old = 0;
      if (rv && rhd) begin
        old = arch_q.pop_front();
        arch_q.push_back(spec_q[0]);
      end
      step(req, stl, fls, rv, rhd, old);
    end
    for (int i = 0; i < 20; i++) step(2'b11, 0, 0, 0, 0, 0);

    step(2'b00, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
    chk("grant_leftover", gr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage: a circular buffer of free physical tags that hands out up to two destination tags per cycle to rename and reclaims the superseded tag of each retiring instruction. It is the allocation and free counterpart of the physical register file's busy/retire bookkeeping. Rename's `rd_phy_busy_0/1` come from here, and retire's `rd_phy_old_commit` returns here. A committed-head pointer restores all speculative allocations in one cycle on flush.

## Interface
- `ARCH_REGS`, 32, architectural registers; tags 0..ARCH_REGS-1 are mapped at reset and never start free.
- `PHY_REGS`, 64, physical registers.
- `PHY_WIDTH`, 6, tag width, equal to log2(PHY_REGS).
- `FL_DEPTH`, PHY_REGS-ARCH_REGS (32), free-list capacity.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `stall` in 1: rename stalled; no allocation commits.
- `flush` in 1: misprediction recovery; discards speculative allocations.
- `alloc_req` in 2: per rename slot, the instruction writes a non-x0 rd.
- `alloc_ready` out 1: free_count ≥ 2; rename may fire.
- `alloc_valid` out 2: `alloc_req` & fire, where fire = alloc_ready & !stall & !flush.
- `alloc_phy_0` / `alloc_phy_1` out PHY_WIDTH: tags granted to slot 0 and slot 1.
- `retire_valid` in 1: one instruction retires this cycle.
- `retire_has_rd` in 1: the retiring instruction allocated a tag.
- `rd_phy_old_commit` in PHY_WIDTH: superseded tag to free.
- `free_count` out PHY_WIDTH+1: number of free entries, tail − head.

## Operation
- **Storage:** `fl[FL_DEPTH]` of tags.
- **Pointers:** `head`, `commit_head` and `tail`, each log2(FL_DEPTH)+1 bits. The MSB is a wrap bit; the low bits index the array.
- **Reset:**
  - fl[i] = ARCH_REGS+i.
  - head = commit_head = 0.
  - tail = {1'b1, 0…}, so the list is full.
  - free_count = FL_DEPTH, alloc_ready = 1, alloc_valid = 0.
- **Tag grant order:**
  - alloc_phy_0 = fl[head].
  - alloc_phy_1 = fl[head+1] if alloc_req[0], else fl[head], so slot 1 alone takes the head entry.
  - Outputs are combinational from the pointers and valid regardless of fire. Rename qualifies them with alloc_valid.
- **Allocate:** on fire, head += popcount(alloc_req), which is 0, 1 or 2.
- **Free:** on retire_valid & retire_has_rd:
  - fl[tail] ← rd_phy_old_commit, then tail += 1.
  - commit_head += 1, because the retiring instruction's own allocation is now architectural.
  - retire_valid with !retire_has_rd changes nothing.
- **Flush:** head ← commit_head', where commit_head' includes any same-cycle retire increment. No allocation occurs that cycle. Tail is unaffected.
- **Stall independence:** stall gates allocation only. Retire and free proceed under stall and under flush.
- **Boundaries:**
  - free_count < 2 forces alloc_ready = 0, even for a single request.
  - Allocate and free in the same cycle touch different slots; the new free_count = old − popcount + 1.
  - A freed tag becomes allocatable the next cycle; there is no bypass.
  - All pointers wrap modulo 2·FL_DEPTH.
  - Freeing when free_count == FL_DEPTH is illegal and is asserted. Freeing a tag < 1 (p0, hard-wired x0) is illegal and is asserted.
- **Invariants, asserted:**
  - commit_head ≤ head ≤ tail, modulo wrap.
  - tail − commit_head ≤ FL_DEPTH.

## Timing
- Grant latency is 0 cycles: tags are visible the same cycle as the request.
- Head advances at the posedge where fire is sampled.
- Free latency is 1 cycle from the retire posedge to the tag appearing in fl and in free_count.
- Flush takes 1 cycle: after the flush posedge, free_count = tail − commit_head.
- Reset is asynchronous assert with immediate output values. Deassertion is synchronized externally. Reset mid-operation discards all in-flight state, and the list returns to full.

## Structure
- `parameter_pkg` holds ARCH_REGS, PHY_REGS, PHY_WIDTH and FL_DEPTH, plus FL_PTR_W = $clog2(FL_DEPTH)+1.
- `typedef_pkg` holds `phy_tag_t` (logic [PHY_WIDTH-1:0]) and `fl_ptr_t`.
- No sub-module: a single always_ff for pointers and array, an always_comb for grants and counts, and embedded SVA.

## Test plan
- **Reset then dual allocate:** rst_n low then high; alloc_req=2'b11 for 3 cycles with stall=0. Tags must be 32,33 then 34,35 then 36,37, and free_count must read 32→30→28→26.
- **Single slot 1:** alloc_req=2'b10 with head at 4. alloc_phy_1 = fl[4] = 36, and head advances by 1 only.
- **Drain to limit:** allocate 15 pairs, which leaves free_count=2. Allocate one more pair; free_count must be 0 and alloc_ready=0. Retire one tag (40); alloc_ready must stay 0 with free_count=1. Retire another; alloc_ready=1 the following cycle.
- **Flush recovery:** allocate 6 tags, then retire 2 with has_rd (tags 5 and 7). Assert flush in the same cycle as a third retire. head must equal commit_head = 3, and free_count must be 32−3+3 = 32. The next grants must reissue fl[3], which is 35.
- **Stall and same-cycle events:** stall=1 with alloc_req=2'b11 and retire_valid=1: head is unchanged and free_count increases by 1. Then stall=0 with alloc_req=2'b01 plus a retire: free_count is unchanged.
- **Wrap-around:** cycle 100 alloc/free pairs. Pointers must wrap with no tag duplicated or lost; a scoreboard checks that the multiset of free ∪ allocated tags equals {32..63} ∪ freed architectural tags.
